// File: rtl/zmod_txrst_seq.sv
// TX reset/enable sequencer on the TX PLL divided clock.
// Qualifies pll_locked, then releases serdes_rst, fifo_rst, and raises tx_en in order.
// Optional TRAIN state: define ZMOD_TXRST_TRAIN_EN.
// Ports:
//   clk        - TX PLL divided clock (sole clock)
//   rst        - asynchronous active-high reset
//   pll_locked - PLL lock, asynchronous to clk
//   serdes_rst - serializer reset (active-high, registered)
//   fifo_rst   - TX FIFO/gearbox reset (active-high, registered)
//   tx_en      - TX datapath enable, high only in RUN (registered)
//   train      - training request, high only in TRAIN (0 without macro)
//   loss_cnt   - saturating count of lock losses from RUN/TRAIN
module zmod_txrst_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int SERDES_DLY    = 16,
  parameter int FIFO_DLY      = 8,
  parameter int TRAIN_CYCLES  = 256,
  parameter int LOSS_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              serdes_rst,
  output logic              fifo_rst,
  output logic              tx_en,
  output logic              train,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int M1   = (STABLE_CYCLES > SERDES_DLY) ? STABLE_CYCLES : SERDES_DLY;
  localparam int M2   = (M1 > FIFO_DLY) ? M1 : FIFO_DLY;
  localparam int MAXP = (M2 > TRAIN_CYCLES) ? M2 : TRAIN_CYCLES;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    SERDES_REL,
    FIFO_REL,
    TRAIN,
    RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [LOSS_W-1:0]       loss_q, loss_d;
  logic                    lock_s;
  logic                    serdes_rst_q, fifo_rst_q, tx_en_q;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (state_q != WAIT_LOCK && !lock_s) begin
      // lock loss outranks every timed transition
      state_d = WAIT_LOCK;
    end else begin
      unique case (state_q)
        WAIT_LOCK: if (lock_s) state_d = STABLE;
        STABLE: begin
          cnt_d = cnt_inc;
          if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = SERDES_REL;
        end
        SERDES_REL: begin
          cnt_d = cnt_inc;
          if (cnt_q == CW'(SERDES_DLY - 1)) state_d = FIFO_REL;
        end
        FIFO_REL: begin
          cnt_d = cnt_inc;
`ifdef ZMOD_TXRST_TRAIN_EN
          if (cnt_q == CW'(FIFO_DLY - 1)) state_d = TRAIN;
`else
          if (cnt_q == CW'(FIFO_DLY - 1)) state_d = RUN;
`endif
        end
`ifdef ZMOD_TXRST_TRAIN_EN
        TRAIN: begin
          cnt_d = cnt_inc;
          if (cnt_q == CW'(TRAIN_CYCLES - 1)) state_d = RUN;
        end
`endif
        RUN:     state_d = RUN;
        default: state_d = WAIT_LOCK;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    loss_d = loss_q;
    if ((state_q == RUN || state_q == TRAIN) && !lock_s && loss_q != '1)
      loss_d = loss_q + LOSS_W'(1);
  end

  // outputs decoded from next state so they move with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      sync_q       <= '0;
      loss_q       <= '0;
      serdes_rst_q <= 1'b1;
      fifo_rst_q   <= 1'b1;
      tx_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      loss_q       <= loss_d;
      serdes_rst_q <= (state_d == WAIT_LOCK) || (state_d == STABLE);
      fifo_rst_q   <= (state_d == WAIT_LOCK) || (state_d == STABLE)
                   || (state_d == SERDES_REL);
      tx_en_q      <= (state_d == RUN);
    end
  end

`ifdef ZMOD_TXRST_TRAIN_EN
  logic train_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) train_q <= 1'b0;
    else     train_q <= (state_d == TRAIN);
  end
  assign train = train_q;
`else
  assign train = 1'b0;
`endif

  assign serdes_rst = serdes_rst_q;
  assign fifo_rst   = fifo_rst_q;
  assign tx_en      = tx_en_q;
  assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_zmod_txrst_seq.sv
// Bench for zmod_txrst_seq: table of {lock, edges, expected outputs} rows
// plus hand-written async-reset sequences.
module tb_zmod_txrst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       serdes_rst, fifo_rst, tx_en, train;
  logic [1:0] loss_cnt;

  int n_run  = 0;
  int n_fail = 0;

  zmod_txrst_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .SERDES_DLY   (4),
    .FIFO_DLY     (4),
    .TRAIN_CYCLES (5),
    .LOSS_W       (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .serdes_rst(serdes_rst),
    .fifo_rst  (fifo_rst),
    .tx_en     (tx_en),
    .train     (train),
    .loss_cnt  (loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lock;
    int         n;
    logic       sr;
    logic       fr;
    logic       en;
    logic       tr;
    logic [1:0] loss;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic lock, input int n, input logic sr,
                     input logic fr, input logic en, input logic tr,
                     input logic [1:0] loss);
    vec_t v;
    v.lock = lock; v.n = n; v.sr = sr; v.fr = fr;
    v.en = en; v.tr = tr; v.loss = loss;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {serdes_rst, fifo_rst, tx_en, train, loss_cnt};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sr,fr,en,tr,loss}=%b want %b", name, act, exp);
    end
  endtask

  // rows after serdes_rst has just fallen (FIFO release onward)
  task automatic add_from_serdes(input logic [1:0] l);
    add(1, 3, 0, 1, 0, 0, l);
    add(1, 1, 0, 0, 0, 0, l);
    add(1, 3, 0, 0, 0, 0, l);
`ifdef ZMOD_TXRST_TRAIN_EN
    add(1, 1, 0, 0, 0, 1, l);
    add(1, 4, 0, 0, 0, 1, l);
    add(1, 1, 0, 0, 1, 0, l);
`else
    add(1, 1, 0, 0, 1, 0, l);
`endif
    add(1, 5, 0, 0, 1, 0, l);
  endtask

  // first row's edge is edge 1 of a fresh lock
  task automatic add_relock(input logic [1:0] l);
    add(1, 10, 1, 1, 0, 0, l);
    add(1, 1, 0, 1, 0, 0, l);
    add_from_serdes(l);
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) begin
      pll_locked = tbl[i].lock;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", name, i),
            {tbl[i].sr, tbl[i].fr, tbl[i].en, tbl[i].tr, tbl[i].loss});
    end
    tbl.delete();
  endtask

  initial begin
    logic [1:0] prev, cur;
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_hold_nolock", 6'b110000);
    pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rst_hold_lock", 6'b110000);
    pll_locked = 1'b0;
    rst = 1'b0;

    // lock glitch while STABLE with cnt=5: pll_locked low at edge 7
    add(1, 6, 1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0);
    add(1, 10, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    add_from_serdes(0);
    run_tbl("stable_glitch");

    // four lock losses from RUN, loss_cnt saturates at 3
    for (int k = 1; k <= 4; k++) begin
      prev = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
      cur  = (k > 3) ? 2'd3 : 2'(k);
      add(0, 2, 0, 0, 1, 0, prev);
      add(0, 1, 1, 1, 0, 0, cur);
      add(0, 3, 1, 1, 0, 0, cur);
      add_relock(cur);
      run_tbl($sformatf("loss%0d", k));
    end

    // async reset mid-RUN, no clock edge needed
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_rst", 6'b110000);
    repeat (2) @(posedge clk);
    #1 check("async_rst_hold", 6'b110000);
    pll_locked = 1'b1;
    rst = 1'b0;
    add_relock(0);
    run_tbl("after_rst");

`ifdef ZMOD_TXRST_TRAIN_EN
    add(0, 2, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1);
    add(1, 10, 1, 1, 0, 0, 1);
    add(1, 1, 0, 1, 0, 0, 1);
    add(1, 3, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1);
    add(1, 3, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    add(0, 2, 0, 0, 0, 1, 1);
    add(0, 1, 1, 1, 0, 0, 2);
    run_tbl("train_loss");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
